// File: rtl/alu_seq.sv
// Registered valid/ready ALU (AND..SRA, SLT, flags); ALU_MUL_EN adds an iterative shift-add MUL on opcode 8.
// Latency 1 clk (MUL WIDTH+1); results hold while out_ready=0 and in_ready drops until the result drains.
module alu_seq #(
  parameter int WIDTH     = 8,
  parameter int SHIFT     = $clog2(WIDTH),
  parameter int OPERATION = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERATION-1:0] operation,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic [SHIFT-1:0]     shamt,
  input  logic                 carry_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 carry,
  output logic                 overflow,
  output logic                 zero,
  output logic                 illegal
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DONE = 2'd2;
`ifdef ALU_MUL_EN
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [OPERATION-1:0] OP_MUL = OPERATION'(8);
  localparam logic [SHIFT-1:0] CNT_INIT = SHIFT'(WIDTH - 1);
`endif

  localparam logic [OPERATION-1:0] OP_AND = OPERATION'(0);
  localparam logic [OPERATION-1:0] OP_OR  = OPERATION'(1);
  localparam logic [OPERATION-1:0] OP_XOR = OPERATION'(2);
  localparam logic [OPERATION-1:0] OP_ADD = OPERATION'(3);
  localparam logic [OPERATION-1:0] OP_SUB = OPERATION'(4);
  localparam logic [OPERATION-1:0] OP_SLL = OPERATION'(5);
  localparam logic [OPERATION-1:0] OP_SRL = OPERATION'(6);
  localparam logic [OPERATION-1:0] OP_SLT = OPERATION'(7);
  localparam logic [OPERATION-1:0] OP_SRA = OPERATION'(9);
  localparam logic [SHIFT:0]       WIDTH_L = (SHIFT + 1)'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHIFT-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_nxt;
`endif

  logic             accept;
  logic             op_is_mul;
  logic [WIDTH-1:0] op_res;
  logic             op_carry, op_ovf, op_illegal;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH-1:0] diff;
  logic             shamt_big;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  // Only reachable when WIDTH is not a power of two.
  assign shamt_big = ({1'b0, shamt} >= WIDTH_L);
  assign add_ext   = {1'b0, x} + {1'b0, y} + (WIDTH + 1)'(carry_in);
  assign diff      = x - y;

  always_comb begin
    op_res     = '0;
    op_carry   = 1'b0;
    op_ovf     = 1'b0;
    op_illegal = 1'b0;
    op_is_mul  = 1'b0;
    case (operation)
      OP_AND: op_res = x & y;
      OP_OR:  op_res = x | y;
      OP_XOR: op_res = x ^ y;
      OP_ADD: begin
        op_res   = add_ext[WIDTH-1:0];
        op_carry = add_ext[WIDTH];
        op_ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (add_ext[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        op_res   = diff;
        op_carry = (x >= y);
        op_ovf   = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SLL: op_res = shamt_big ? '0 : (x << shamt);
      OP_SRL: op_res = shamt_big ? '0 : (x >> shamt);
      OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SRA: op_res = shamt_big ? {WIDTH{x[WIDTH-1]}} : $unsigned($signed(x) >>> shamt);
`ifdef ALU_MUL_EN
      OP_MUL: op_is_mul = 1'b1;
`endif
      default: op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    illegal_d  = illegal_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    if (accept) begin
      if (op_is_mul) begin
`ifdef ALU_MUL_EN
        state_d  = BUSY;
        mcand_d  = x;
        mplier_d = y;
        acc_d    = '0;
        cnt_d    = CNT_INIT;
`endif
      end else begin
        state_d    = DONE;
        result_d   = op_res;
        carry_d    = op_carry;
        overflow_d = op_ovf;
        zero_d     = (op_res == '0);
        illegal_d  = op_illegal;
      end
    end else if ((state_q == DONE) && out_ready) begin
      state_d = IDLE;
    end
`ifdef ALU_MUL_EN
    // One partial product per clock; accept and BUSY are mutually exclusive.
    if (state_q == BUSY) begin
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d    = DONE;
        result_d   = acc_nxt;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        zero_d     = (acc_nxt == '0);
        illegal_d  = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      illegal_q  <= illegal_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule
